// File: rtl/spi_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// spi_mem_loader_pkg
// Shared definitions for the serial memory loader: frame geometry, default
// memory sizes, loader state encodings and a small range-check helper.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_mem_loader_pkg;

    localparam int FRAME_W     = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_IMEM_SZ = 16;
    localparam int DEF_DMEM_SZ = 15;

    // Bit counter is wide enough to hold FRAME_W+1, the saturation value that
    // marks an over-long frame.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_COMMIT = 2'b10,
        ST_DRAIN  = 2'b11
    } loader_state_t;

    function automatic logic addr_in_range(input int addr, input int size);
        return (addr < size);
    endfunction

endpackage

// File: rtl/spi_mem_loader_shift_reg.sv
// ---------------------------------------------------------------------------
// loader_shift_reg
// Serial-in / parallel-out frame register with a saturating bit counter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      start of frame: discard old contents and load bit_in as the
//              first bit (count becomes 1)
//   shift_en   shift bit_in in at the LSB end, count up (saturating)
//   bit_in     serial data
//   data       parallel frame contents, first bit received ends up at MSB
//   count      number of bits received, saturates at W+1
// ---------------------------------------------------------------------------
module loader_shift_reg
    import spi_mem_loader_pkg::*;
#(
    parameter int W       = FRAME_W,
    parameter int COUNT_W = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [W-1:0]       data,
    output logic [COUNT_W-1:0] count
);

    // Saturating at W+1 lets the controller tell "exactly W bits" apart from
    // "too many bits" without a wider counter.
    localparam logic [COUNT_W-1:0] COUNT_SAT = COUNT_W'(W + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= {{(W-1){1'b0}}, bit_in};
            count <= COUNT_W'(1);
        end else if (shift_en) begin
            data <= {data[W-2:0], bit_in};
            if (count != COUNT_SAT) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_mem_loader.sv
// ---------------------------------------------------------------------------
// spi_mem_loader
// Serial program/data loader between the external SPI-style pins and the
// core's instruction and data memories. Shifts in 12-bit frames
// {data[7:0], addr[3:0]} MSB first, validates length, address and core state,
// and issues one single-cycle write strobe per valid frame.
//
// Optional feature: define SPI_MEM_LOADER_READBACK_EN to shift the data
// memory word at the last committed data-memory address out on miso_out
// during a csd frame. Without it miso_out is 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   csi_n_in        instruction-memory select (active low)
//   csd_n_in        data-memory select (active low)
//   mosi_in         serial data in, sampled each rising edge while selected
//   core_busy_in    core executing; new loads refused while high
//   dmem_rdata_in   data memory combinational read data at mem_addr_out
//   mem_addr_out    address to both memories
//   mem_wdata_out   write data to both memories
//   imem_wen_out    instruction memory write strobe
//   dmem_wen_out    data memory write strobe
//   miso_out        serial readback data
//   busy_out        loader owns the memory ports
//   err_out         sticky frame error, cleared by the next frame start
// ---------------------------------------------------------------------------
module spi_mem_loader
    import spi_mem_loader_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int IMEM_SZ = DEF_IMEM_SZ,
    parameter int DMEM_SZ = DEF_DMEM_SZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csi_n_in,
    input  logic              csd_n_in,
    input  logic              mosi_in,
    input  logic              core_busy_in,
    input  logic [DATA_W-1:0] dmem_rdata_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic              imem_wen_out,
    output logic              dmem_wen_out,
    output logic              miso_out,
    output logic              busy_out,
    output logic              err_out
);

    localparam int FW = DATA_W + ADDR_W;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FW);

    loader_state_t     state;
    loader_state_t     state_next;
    logic              tgt_dmem;
    logic              tgt_load;
    logic              sr_clear;
    logic              sr_shift;
    logic              err_set;
    logic              err_clr;
    logic [FW-1:0]     frame;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] frame_addr;
    logic              sel_n;
    logic              other_n;
    logic              addr_ok;

    loader_shift_reg #(
        .W       (FW),
        .COUNT_W (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (sr_clear),
        .shift_en (sr_shift),
        .bit_in   (mosi_in),
        .data     (frame),
        .count    (count)
    );

    assign frame_addr = frame[ADDR_W-1:0];

    // The select latched at frame start, and the one that must stay high.
    assign sel_n   = tgt_dmem ? csd_n_in : csi_n_in;
    assign other_n = tgt_dmem ? csi_n_in : csd_n_in;
    assign addr_ok = tgt_dmem ? addr_in_range(int'(frame_addr), DMEM_SZ)
                              : addr_in_range(int'(frame_addr), IMEM_SZ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tgt_dmem <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            state <= state_next;
            if (tgt_load) begin
                tgt_dmem <= ~csd_n_in;
            end
            if (err_set) begin
                err_out <= 1'b1;
            end else if (err_clr) begin
                err_out <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        tgt_load   = 1'b0;
        sr_clear   = 1'b0;
        sr_shift   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!csi_n_in && !csd_n_in) begin
                    err_set    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (!csi_n_in || !csd_n_in) begin
                    if (core_busy_in) begin
                        err_set    = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        err_clr    = 1'b1;
                        sr_clear   = 1'b1;
                        tgt_load   = 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // A second select during a frame is a bus conflict; it wins
                // over a simultaneous end of frame.
                if (!other_n) begin
                    err_set    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (!sel_n) begin
                    sr_shift = 1'b1;
                end else if (count == FULL_COUNT && addr_ok) begin
                    state_next = ST_COMMIT;
                end else begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (csi_n_in && csd_n_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef SPI_MEM_LOADER_READBACK_EN
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_addr <= '0;
        end else if (state == ST_COMMIT && tgt_dmem) begin
            rb_addr <= frame_addr;
        end
    end

    // After k frame bits have been taken, word bit (DATA_W-k) is presented.
    assign rb_shifted = dmem_rdata_in << (count - CNT_W'(1));
`else
    logic unused_rdata;
    assign unused_rdata = ^dmem_rdata_in;
`endif

    always_comb begin
        imem_wen_out  = (state == ST_COMMIT) && !tgt_dmem;
        dmem_wen_out  = (state == ST_COMMIT) && tgt_dmem;
        busy_out      = (state != ST_IDLE);
        mem_wdata_out = frame[FW-1:ADDR_W];
        mem_addr_out  = frame_addr;
        miso_out      = 1'b0;
`ifdef SPI_MEM_LOADER_READBACK_EN
        if (state == ST_SHIFT && tgt_dmem) begin
            mem_addr_out = rb_addr;
            if (count != '0 && count <= CNT_W'(DATA_W)) begin
                miso_out = rb_shifted[DATA_W-1];
            end
        end
`endif
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_loader
// Self-checking bench for spi_mem_loader: a table of whole-frame vectors plus
// hand-written sequences for reset, conflicts, strobe latency and readback.
// ---------------------------------------------------------------------------
module tb_spi_mem_loader;

    logic       clk;
    logic       rst;
    logic       csi_n_in;
    logic       csd_n_in;
    logic       mosi_in;
    logic       core_busy_in;
    logic [7:0] dmem_rdata_in;
    logic [3:0] mem_addr_out;
    logic [7:0] mem_wdata_out;
    logic       imem_wen_out;
    logic       dmem_wen_out;
    logic       miso_out;
    logic       busy_out;
    logic       err_out;

    int total;
    int bad;

    int         imem_pulses;
    int         dmem_pulses;
    logic [3:0] last_addr;
    logic [7:0] last_data;
    logic [7:0] dmem_model [16];

    spi_mem_loader dut (
        .clk           (clk),
        .rst           (rst),
        .csi_n_in      (csi_n_in),
        .csd_n_in      (csd_n_in),
        .mosi_in       (mosi_in),
        .core_busy_in  (core_busy_in),
        .dmem_rdata_in (dmem_rdata_in),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .imem_wen_out  (imem_wen_out),
        .dmem_wen_out  (dmem_wen_out),
        .miso_out      (miso_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmem_rdata_in = dmem_model[mem_addr_out];

    always @(posedge clk) begin
        if (dmem_wen_out) begin
            dmem_model[mem_addr_out] <= mem_wdata_out;
        end
    end

    always @(negedge clk) begin
        if (imem_wen_out) begin
            imem_pulses = imem_pulses + 1;
            last_addr   = mem_addr_out;
            last_data   = mem_wdata_out;
        end
        if (dmem_wen_out) begin
            dmem_pulses = dmem_pulses + 1;
            last_addr   = mem_addr_out;
            last_data   = mem_wdata_out;
        end
    end

    typedef struct {
        logic       use_d;
        logic [7:0] data;
        logic [3:0] addr;
        int         nbits;
        logic       busy;
        int         exp_imem;
        int         exp_dmem;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Drives nbits frame bits with the chosen select held low; the select is
    // left low so the caller decides how the frame ends.
    task automatic applyStimulus(input logic use_d, input logic [11:0] frame,
                                 input int nbits);
        csi_n_in = use_d;
        csd_n_in = ~use_d;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = (i < 12) ? frame[11 - i] : 1'b0;
            @(posedge clk);
            #1;
            if (i == 0) begin
                checkOutput("busy_in_frame", 32'(busy_out), 32'd1);
            end
        end
    endtask

    task automatic endFrame();
        csi_n_in = 1'b1;
        csd_n_in = 1'b1;
        mosi_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rb_word;
        total = 0;
        bad   = 0;
        imem_pulses = 0;
        dmem_pulses = 0;
        last_addr = '0;
        last_data = '0;
        for (int i = 0; i < 16; i++) dmem_model[i] = 8'h00;

        vecs[0] = '{1'b0, 8'hA5, 4'h3, 12, 1'b0, 1, 0, 1'b0};
        vecs[1] = '{1'b1, 8'h7E, 4'hF, 12, 1'b0, 0, 0, 1'b1};
        vecs[2] = '{1'b1, 8'h7E, 4'h2, 12, 1'b0, 0, 1, 1'b0};
        vecs[3] = '{1'b0, 8'h5A, 4'h1,  9, 1'b0, 0, 0, 1'b1};
        vecs[4] = '{1'b0, 8'h12, 4'h1, 12, 1'b0, 1, 0, 1'b0};
        vecs[5] = '{1'b0, 8'h33, 4'h4, 14, 1'b0, 0, 0, 1'b1};
        vecs[6] = '{1'b1, 8'h99, 4'h6, 12, 1'b1, 0, 0, 1'b1};
        vecs[7] = '{1'b1, 8'hC3, 4'hE, 12, 1'b0, 0, 1, 1'b0};
        vecs[8] = '{1'b0, 8'hFF, 4'hF, 12, 1'b0, 1, 0, 1'b0};
        vecs[9] = '{1'b1, 8'h00, 4'h0, 11, 1'b0, 0, 0, 1'b1};

        rst          = 1'b1;
        csi_n_in     = 1'b1;
        csd_n_in     = 1'b1;
        mosi_in      = 1'b0;
        core_busy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_err", 32'(err_out), 32'd0);
        checkOutput("rst_wen", 32'({imem_wen_out, dmem_wen_out}), 32'd0);
        checkOutput("rst_miso", 32'(miso_out), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr_out), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata_out), 32'd0);

        for (int v = 0; v < 10; v++) begin
            imem_pulses  = 0;
            dmem_pulses  = 0;
            core_busy_in = vecs[v].busy;
            applyStimulus(vecs[v].use_d, {vecs[v].data, vecs[v].addr}, vecs[v].nbits);
            endFrame();
            core_busy_in = 1'b0;
            checkOutput($sformatf("v%0d_imem_pulses", v), 32'(imem_pulses), 32'(vecs[v].exp_imem));
            checkOutput($sformatf("v%0d_dmem_pulses", v), 32'(dmem_pulses), 32'(vecs[v].exp_dmem));
            checkOutput($sformatf("v%0d_err", v), 32'(err_out), 32'(vecs[v].exp_err));
            checkOutput($sformatf("v%0d_idle", v), 32'(busy_out), 32'd0);
            if (vecs[v].exp_imem + vecs[v].exp_dmem > 0) begin
                checkOutput($sformatf("v%0d_addr", v), 32'(last_addr), 32'(vecs[v].addr));
                checkOutput($sformatf("v%0d_data", v), 32'(last_data), 32'(vecs[v].data));
            end
        end

        // Reset in the middle of a frame: frame dropped, outputs at reset values.
        imem_pulses = 0;
        dmem_pulses = 0;
        applyStimulus(1'b0, {8'hB7, 4'h9}, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        csi_n_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_err", 32'(err_out), 32'd0);
        checkOutput("midrst_busy", 32'(busy_out), 32'd0);
        checkOutput("midrst_addr", 32'(mem_addr_out), 32'd0);
        checkOutput("midrst_wdata", 32'(mem_wdata_out), 32'd0);
        checkOutput("midrst_pulses", 32'(imem_pulses + dmem_pulses), 32'd0);

        // Strobe latency: wen high the cycle after the select is seen high.
        applyStimulus(1'b0, {8'h81, 4'h4}, 12);
        csi_n_in = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("lat_imem_wen", 32'(imem_wen_out), 32'd1);
        checkOutput("lat_dmem_wen", 32'(dmem_wen_out), 32'd0);
        checkOutput("lat_addr", 32'(mem_addr_out), 32'd4);
        checkOutput("lat_wdata", 32'(mem_wdata_out), 32'h81);
        checkOutput("lat_busy", 32'(busy_out), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("lat_wen_drop", 32'(imem_wen_out), 32'd0);
        checkOutput("lat_idle", 32'(busy_out), 32'd0);

        // Other select falls mid-frame: conflict, drain, no write.
        imem_pulses = 0;
        dmem_pulses = 0;
        applyStimulus(1'b0, {8'h44, 4'h2}, 5);
        csd_n_in = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("conflict_err", 32'(err_out), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("conflict_drain", 32'(busy_out), 32'd1);
        endFrame();
        checkOutput("conflict_idle", 32'(busy_out), 32'd0);
        checkOutput("conflict_pulses", 32'(imem_pulses + dmem_pulses), 32'd0);

        // Both selects falling together.
        csi_n_in = 1'b0;
        csd_n_in = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("both_err", 32'(err_out), 32'd1);
        checkOutput("both_busy", 32'(busy_out), 32'd1);
        endFrame();
        checkOutput("both_idle", 32'(busy_out), 32'd0);
        checkOutput("both_err_sticky", 32'(err_out), 32'd1);
        checkOutput("both_pulses", 32'(imem_pulses + dmem_pulses), 32'd0);
        checkOutput("nomacro_miso", 32'(miso_out), 32'd0);

`ifdef SPI_MEM_LOADER_READBACK_EN
        applyStimulus(1'b1, {8'h3C, 4'h5}, 12);
        endFrame();
        checkOutput("rb_stored", 32'(dmem_model[5]), 32'h3C);
        rb_word = 8'h3C;
        csd_n_in = 1'b0;
        csi_n_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mosi_in = 1'b0;
            @(posedge clk);
            #1;
            checkOutput($sformatf("rb_miso_bit%0d", i), 32'(miso_out), 32'(rb_word[7 - i]));
        end
        @(posedge clk);
        #1;
        checkOutput("rb_miso_tail", 32'(miso_out), 32'd0);
        endFrame();
`else
        rb_word = 8'h00;
        checkOutput("nomacro_word", 32'(rb_word), 32'(mem_addr_out & 4'h0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_loader.md
Name: spi_mem_loader

Overview:
- Serial program/data loader sitting between the external SPI-style master pins and the core's instruction and data memories.
- Shifts in 12-bit frames under active-low chip selects and validates length, address and core state.
- Issues exactly one single-cycle write strobe per valid frame.
- Replaces ad-hoc RECV/WRITE sequencing in the core control so program loading and data preloading share one sequenced path.

Parameters:
- DATA_W, 8, memory word width.
- ADDR_W, 4, memory address width.
- IMEM_SZ, 16, instruction memory entries; valid addresses 0..IMEM_SZ-1.
- DMEM_SZ, 15, data memory entries; valid addresses 0..DMEM_SZ-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- csi_n_in  in  1  instruction-memory chip select, active low.
- csd_n_in  in  1  data-memory chip select, active low.
- mosi_in  in  1  serial data, sampled on every rising clk edge while a select is low.
- core_busy_in  in  1  core executing; loads are refused while high.
- dmem_rdata_in  in  DATA_W  data memory read data at mem_addr_out (combinational memory read).
- mem_addr_out  out  ADDR_W  write/read address to both memories.
- mem_wdata_out  out  DATA_W  write data to both memories.
- imem_wen_out  out  1  instruction memory write strobe.
- dmem_wen_out  out  1  data memory write strobe.
- miso_out  out  1  serial readback data.
- busy_out  out  1  loader owns the memory ports; the core must not start while high.
- err_out  out  1  sticky frame error.

Behaviour:
- Frame format: 12 bits, MSB first. The first bit received is frame[11]. frame = {data[7:0], addr[3:0]}.
- Target selection: latched when the frame starts. csi low means instruction memory; csd low means data memory.
- States: IDLE, SHIFT, COMMIT, DRAIN.
- IDLE:
  - Both selects high: remain in IDLE.
  - Exactly one select low: clear err_out, clear the shift register and bit count, capture the first bit, go to SHIFT.
  - Both selects low: set err_out, go to DRAIN.
  - core_busy_in high when a select falls: set err_out, go to DRAIN.
- SHIFT:
  - While the latched select stays low: shift in one bit per cycle. The bit count saturates at 13.
  - Latched select rises with count==12 and the address in range (IMEM_SZ for csi, DMEM_SZ for csd): go to COMMIT.
  - Latched select rises otherwise: set err_out, go to IDLE, no write.
  - Other select falls mid-frame: set err_out, go to DRAIN.
- COMMIT: lasts one cycle. The selected wen is high for exactly this cycle. mem_addr_out and mem_wdata_out are held from the frame. Next state is IDLE.
- DRAIN: wait until both selects are high, then go to IDLE. No writes occur in DRAIN.
- Latency: the select is sampled high at edge N; the wen is high during the cycle after edge N; the state is IDLE after edge N+1.
- busy_out is high in SHIFT, COMMIT and DRAIN.
- mem_addr_out and mem_wdata_out reflect the shift register at all times. They are only qualified by the wen strobes.
- The shift register is not reset by a completed or aborted frame; it is cleared only at the start of a new frame.
- Address 15 with csd is out of range (DMEM_SZ=15): err_out is set and no write occurs.
- Reset:
  - Reset values: state IDLE, count 0, shift register 0, err_out 0, both wens 0, miso_out 0, busy_out 0.
  - Reset mid-frame discards the frame with no write. After reset, a select that is still held low is treated as a new frame start only if core_busy_in is low.
- core_busy_in rising during SHIFT does not abort the frame. The core is held off by busy_out.

Optional Feature:
- Macro: SPI_MEM_LOADER_READBACK_EN.
- With the macro defined:
  - During a csd frame, miso_out shifts out the data memory word at the address of the previous committed dcache frame, MSB first, on frame bits 0..7, then 0.
  - The readback address is held in a 4-bit register, reset to 0.
  - mem_addr_out shows the readback address while in SHIFT for csd, and switches to the frame address in COMMIT.
- Without the macro: miso_out is tied to 0, and mem_addr_out always shows the frame address.

Decomposition:
- Shared package/header:
  - Loader state encodings: IDLE=2'b00, SHIFT=2'b01, COMMIT=2'b10, DRAIN=2'b11.
  - FRAME_W=12, the DATA_W/ADDR_W defaults and the IMEM_SZ/DMEM_SZ constants.
- Sub-module: one natural sub-module, loader_shift_reg. It is a FRAME_W serial-in/parallel-out register with synchronous clear and a saturating bit counter.

Test Plan:
- csi low for 12 cycles shifting 0xA5 then addr 0x3, then csi high → imem_wen_out high for exactly one cycle with addr 3, data 0xA5; err_out stays 0.
- csd frame with data 0x7E, addr 0xF → no dmem_wen_out, err_out 1; the next valid csd frame with addr 0x2 clears err_out and writes 0x7E-pattern data.
- csi low for 9 cycles then high → no write, err_out 1, state IDLE; csi low for 14 cycles → err_out 1, no write.
- core_busy_in=1 when csd falls → busy_out 1, no write even after 12 bits, err_out 1; returns to IDLE when csd rises.
- Assert rst at bit 6 of a frame, release with csi high → all outputs at reset values; a following full frame writes correctly.
- READBACK_EN: commit 0x3C to dmem addr 5, then a csd frame → miso_out emits 0,0,1,1,1,1,0,0 on bits 0..7.
